// File: rtl/quad_seven_seg_driver_pkg.sv
// Shared constants for the four-digit seven-segment driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package quad_seven_seg_driver_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_DIGIT0 = 4'b1110;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [3:0] an_for_idx(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/quad_seven_seg_driver_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; 10-15 render as a dash.
module bcd_to_seg7
    import quad_seven_seg_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup of the active-low segment pattern.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/quad_seven_seg_driver.sv
// Time-multiplexed four-digit seven-segment driver with per-frame input
// snapshot (no tearing), leading-zero blanking and decimal points.
module quad_seven_seg_driver
    import quad_seven_seg_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] num0,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    input  logic [3:0] num3,
    input  logic [3:0] dp_in,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0]   cnt;
    logic            tick;
    logic [1:0]      idx;
    logic [1:0]      idx_nxt;
    logic            frame_start;

    logic [3:0][3:0] snap;
    logic [3:0]      snap_dp;
    logic            snap_blank;

    // Values the next digit is drawn from: live inputs on the edge that
    // starts a frame (they are being captured on that edge), else the snapshot.
    logic [3:0][3:0] frame;
    logic [3:0]      frame_dp;
    logic            frame_blank;

    logic [3:0]      digit;
    logic [6:0]      dec_seg;
    logic            hi_zero;
    logic            blank_digit;
    logic [6:0]      seg_nxt;

    assign tick        = (cnt == CW'(REFRESH_DIV - 1));
    assign idx_nxt     = idx + 2'd1;
    assign frame_start = (idx_nxt == 2'd0);

    // Select the frame source for the digit about to be displayed.
    always_comb begin
        frame       = snap;
        frame_dp    = snap_dp;
        frame_blank = snap_blank;
        if (frame_start) begin
            frame       = {num3, num2, num1, num0};
            frame_dp    = dp_in;
            frame_blank = blank_lz;
        end
    end

    assign digit = frame[idx_nxt];

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

    // Blank a non-zero-index digit when it and every higher digit are zero.
    always_comb begin
        hi_zero = 1'b1;
        for (int j = 1; j < 4; j++) begin
            if (j >= int'(idx_nxt) && frame[j] != 4'd0) hi_zero = 1'b0;
        end
        blank_digit = frame_blank && (idx_nxt != 2'd0) && hi_zero;
        seg_nxt     = blank_digit ? SEG_BLANK : dec_seg;
    end

    // Prescaler, scan index, frame snapshot and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            snap       <= '0;
            snap_dp    <= 4'd0;
            snap_blank <= 1'b0;
            an         <= AN_DIGIT0;
            seg        <= SEG_0;
            dp         <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= idx_nxt;
                if (frame_start) begin
                    snap       <= {num3, num2, num1, num0};
                    snap_dp    <= dp_in;
                    snap_blank <= blank_lz;
                end
                an  <= an_for_idx(idx_nxt);
                seg <= seg_nxt;
                dp  <= ~frame_dp[idx_nxt];
            end
        end
    end

endmodule
